// File: rtl/data_mem_responder.sv
// Handshake data memory target: accepts one load/store at a time on a
// valid/ready pair and answers with a one-cycle response after LATENCY waits.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int AW    = ADDR_WIDTH + 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  lat_write;
    logic [AW-1:0]         lat_addr;
    logic [31:0]           lat_wdata;
    logic [31:0]           mem [DEPTH];

    logic                  cur_write;
    logic [AW-1:0]         cur_addr;
    logic [31:0]           cur_wdata;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic                  cur_misal;
    logic                  enter_resp;
    logic                  mem_we;
    logic                  unused_addr;

    assign unused_addr = ^req_addr[31:AW];
    assign req_ready   = (state == IDLE);

    // With no wait states the commit happens on the accepting edge itself,
    // so the live request must feed the commit path instead of the latches.
    always_comb begin
        cur_write = lat_write;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        if (state == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr[AW-1:0];
            cur_wdata = req_wdata;
        end
    end

    assign cur_idx    = cur_addr[AW-1:2];
    assign cur_misal  = |cur_addr[1:0];
    assign enter_resp = ((state == IDLE) && req_valid && (LATENCY == 0))
                     || ((state == WAIT) && (cnt == 4'd0));
    assign mem_we     = enter_resp && cur_write && !cur_misal;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr[AW-1:0];
                        lat_wdata <= req_wdata;
                        cnt       <= CNT_INIT;
                        state     <= (LATENCY > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= cur_misal;
                resp_rdata <= (cur_misal || cur_write) ? 32'd0 : mem[cur_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (mem_we) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with no wait states and one
// with two, both checked against a word-array model of the memory.
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic        clk;
    logic        Reset;
    logic        req_valid  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    logic [31:0] model  [2][DEPTH];
    logic [31:0] last_r [2];
    logic        last_e [2];

    int n_chk  = 0;
    int n_pass = 0;

    data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(0)) dut0 (
        .clk        (clk),
        .Reset      (Reset),
        .req_valid  (req_valid[0]),
        .req_write  (req_write[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .req_ready  (req_ready[0]),
        .resp_valid (resp_valid[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut2 (
        .clk        (clk),
        .Reset      (Reset),
        .req_valid  (req_valid[1]),
        .req_write  (req_write[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .req_ready  (req_ready[1]),
        .resp_valid (resp_valid[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) model[k][i] = 32'd0;
            last_r[k] = 32'd0;
            last_e[k] = 1'b0;
        end
    endtask

    // One request on instance k; checks ready, pulse timing and payload.
    // hold keeps req_valid high (with junk fields) on the response cycle.
    task automatic do_req(int k, bit wr, logic [31:0] addr,
                          logic [31:0] wd, bit hold);
        int          lat;
        int          idx;
        logic [31:0] exp_r;
        logic        exp_e;
        lat = (k == 0) ? 0 : 2;
        @(negedge clk);
        check("ready_idle", {31'd0, req_ready[k]}, 32'd1);
        check("no_pulse_idle", {31'd0, resp_valid[k]}, 32'd0);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        idx   = int'((addr >> 2) % DEPTH);
        exp_e = (addr % 4) != 0;
        exp_r = 32'd0;
        if (!exp_e) begin
            if (wr) model[k][idx] = wd;
            else    exp_r = model[k][idx];
        end
        @(posedge clk);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            check("ready_busy", {31'd0, req_ready[k]}, 32'd0);
            if (c == lat + 1) begin
                check("resp_valid", {31'd0, resp_valid[k]}, 32'd1);
                check("resp_rdata", resp_rdata[k], exp_r);
                check("resp_err", {31'd0, resp_err[k]}, {31'd0, exp_e});
                last_r[k]    = exp_r;
                last_e[k]    = exp_e;
                req_valid[k] = hold;
            end else begin
                check("early_pulse", {31'd0, resp_valid[k]}, 32'd0);
                check("rdata_held", resp_rdata[k], last_r[k]);
                req_valid[k] = 1'($urandom);
            end
            req_write[k] = 1'($urandom);
            req_addr[k]  = $urandom;
            req_wdata[k] = $urandom;
        end
    endtask

    initial begin
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = 32'd0;
            req_wdata[k] = 32'd0;
        end
        clear_model();
        Reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_valid", {31'd0, resp_valid[k]}, 32'd0);
            check("rst_rdata", resp_rdata[k], 32'd0);
            check("rst_err", {31'd0, resp_err[k]}, 32'd0);
        end
        Reset = 1'b0;

        do_req(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        do_req(1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        do_req(1, 1'b1, 32'h0000_0404, 32'h1234_5678, 1'b0);
        do_req(1, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
        do_req(1, 1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 1'b0);
        do_req(1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            do_req(0, 1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1'b0, 32'(i * 4), 32'h0, i != 3);
        end

        // Store dropped by a reset that lands during its wait states.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h0000_0008;
        req_wdata[1] = 32'hA5A5_A5A5;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        Reset = 1'b1;
        clear_model();
        repeat (3) begin
            @(negedge clk);
            check("rst_no_pulse", {31'd0, resp_valid[1]}, 32'd0);
        end
        Reset = 1'b0;
        do_req(1, 1'b0, 32'h0000_0008, 32'h0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            a = (32'($urandom_range(0, 3)) << 10)
              | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
            do_req(int'($urandom_range(0, 1)), 1'($urandom), a, $urandom,
                   1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
